// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: redirect inputs, instruction-memory port and the IF/ID presentation.
// The master modport is the sequencer's view; the slave modport is its environment's view.
interface fetch_sequencer_if;
   logic        stall_i;
   logic        exc_valid;
   logic        eret_valid;
   logic [31:0] eret_target;
   logic        branch_valid;
   logic [31:0] branch_target;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_addr_err;

   modport master (
      input  stall_i, exc_valid, eret_valid, eret_target, branch_valid, branch_target,
      input  imem_gnt, imem_rvalid, imem_rdata,
      output imem_req, imem_addr,
      output if_valid, if_pc, if_inst, if_addr_err
   );

   modport slave (
      output stall_i, exc_valid, eret_valid, eret_target, branch_valid, branch_target,
      output imem_gnt, imem_rvalid, imem_rdata,
      input  imem_req, imem_addr,
      input  if_valid, if_pc, if_inst, if_addr_err
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Owns the fetch PC, arbitrates redirects (exc > eret > branch > pc+4) and runs a
// single-outstanding req/gnt/rvalid fetch, presenting one instruction at a time to IF/ID.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0380
) (
   input  logic                clk,
   input  logic                rst,
   fetch_sequencer_if.master   bus
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HOLD} state_t;

   state_t      state;
   logic [31:0] pc;

   logic        redirect;
   logic [31:0] tgt;
   logic [31:0] stay_pc;
   logic [31:0] next_pc;

   assign redirect = bus.exc_valid | bus.eret_valid | bus.branch_valid;
   assign tgt      = bus.exc_valid  ? EXC_VECTOR      :
                     bus.eret_valid ? bus.eret_target : bus.branch_target;
   // Where to fetch if we remain on the current PC unless redirected.
   assign stay_pc  = redirect ? tgt : pc;
   // Where to fetch after the presented instruction leaves HOLD.
   assign next_pc  = redirect ? tgt : bus.if_pc + 32'd4;

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         pc              <= RESET_PC;
         bus.imem_req    <= 1'b0;
         bus.imem_addr   <= 32'd0;
         bus.if_valid    <= 1'b0;
         bus.if_addr_err <= 1'b0;
         bus.if_pc       <= 32'd0;
         bus.if_inst     <= 32'd0;
      end else begin
         // Request is only ever re-armed by transitions that land in REQ.
         bus.imem_req <= 1'b0;
         case (state)
            IDLE: begin
               state         <= REQ;
               pc            <= stay_pc;
               bus.imem_addr <= stay_pc;
               bus.imem_req  <= ~|stay_pc[1:0];
            end
            REQ: begin
               if (pc[1:0] != 2'b00 && !redirect) begin
                  // Misaligned PC never reaches memory; present it as an address error.
                  state           <= HOLD;
                  bus.if_valid    <= 1'b1;
                  bus.if_addr_err <= 1'b1;
                  bus.if_pc       <= pc;
                  bus.if_inst     <= 32'd0;
               end else if (bus.imem_req && bus.imem_gnt) begin
                  if (redirect) begin
                     state <= DROP;
                     pc    <= tgt;
                  end else begin
                     state <= WAIT;
                  end
               end else begin
                  pc            <= stay_pc;
                  bus.imem_addr <= stay_pc;
                  bus.imem_req  <= ~|stay_pc[1:0];
               end
            end
            WAIT: begin
               if (bus.imem_rvalid) begin
                  if (redirect) begin
                     state         <= REQ;
                     pc            <= tgt;
                     bus.imem_addr <= tgt;
                     bus.imem_req  <= ~|tgt[1:0];
                  end else begin
                     state           <= HOLD;
                     bus.if_valid    <= 1'b1;
                     bus.if_addr_err <= 1'b0;
                     bus.if_pc       <= pc;
                     bus.if_inst     <= bus.imem_rdata;
                  end
               end else if (redirect) begin
                  state <= DROP;
                  pc    <= tgt;
               end
            end
            DROP: begin
               // Outstanding response is swallowed; redirects keep steering pc meanwhile.
               pc <= stay_pc;
               if (bus.imem_rvalid) begin
                  state         <= REQ;
                  bus.imem_addr <= stay_pc;
                  bus.imem_req  <= ~|stay_pc[1:0];
               end
            end
            HOLD: begin
               if (redirect || !bus.stall_i) begin
                  state           <= REQ;
                  pc              <= next_pc;
                  bus.imem_addr   <= next_pc;
                  bus.imem_req    <= ~|next_pc[1:0];
                  bus.if_valid    <= 1'b0;
                  bus.if_addr_err <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
